instruction_fetch: RTL
======================

# instruction_fetch

Instruction Fetch stage of the SimpleRISC pipeline. Holds the fetch PC and issues word reads to instruction memory over a req/ready handshake. Presents a registered `pc`/`instr` pair with a valid flag to the Operand Fetch stage. Handles downstream stalls with a one-entry skid register and redirects on taken branches from Execute, draining any in-flight memory request first.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP`, default 32'h6800_0000: SimpleRISC `nop`, driven on `instr` when not valid.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: Operand Fetch cannot accept; output register must hold.
- `isBranchTaken` in 1: redirect request from Execute, single-cycle pulse.
- `branchPC` in 32: redirect target; bits [1:0] ignored, treated as 00.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word-aligned read address.
- `imem_ready` in 1: response valid this cycle; memory asserts only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, valid when `imem_ready`=1.
- `pc` out 32: address of `instr`.
- `instr` out 32: fetched instruction.
- `instr_valid` out 1: `pc`/`instr` hold a live instruction.

## Operation
- State: `fetch_pc`[31:0], FSM {FETCH, HOLD, DRAIN}, skid register {skid_instr, skid_pc}, `redirect_pc`[31:0].
- Reset values: state=FETCH, `fetch_pc`=RESET_PC, `pc`=0, `instr`=NOP, `instr_valid`=0, `imem_req`=0, `imem_addr`=RESET_PC.
- `fetch_pc` increments by 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Output consumption: an instruction is consumed in a cycle when `instr_valid`=1 and `stall`=0.
- The output register is free when `instr_valid`=0 or `stall`=0.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`. Address held stable until `imem_ready`.
  - On `imem_ready` with the output register free: load `pc`<=`fetch_pc`, `instr`<=`imem_rdata`, `instr_valid`<=1, `fetch_pc`+=4.
  - On `imem_ready` with the output register not free: capture the response into the skid register, `fetch_pc`+=4, go to HOLD.
  - No `imem_ready` and `stall`=0: `instr_valid`<=0, `instr`<=NOP (bubble).
- HOLD:
  - `imem_req`=0.
  - When `stall`=0: move the skid register to the output, `instr_valid`<=1, go to FETCH.
- Branch (`isBranchTaken`=1) overrides stall and every other event in the same cycle:
  - Output flushed: `instr_valid`<=0, `instr`<=NOP.
  - Skid register discarded.
  - Any `imem_rdata` arriving that cycle is discarded.
  - From FETCH with `imem_ready`=1, or from HOLD: `fetch_pc`<=`branchPC`, go to FETCH.
  - From FETCH with `imem_ready`=0 (request in flight): `redirect_pc`<=`branchPC`, go to DRAIN.
- DRAIN:
  - `imem_req`=1, `imem_addr` keeps the old address.
  - On `imem_ready`: discard data, `fetch_pc`<=`redirect_pc`, go to FETCH.
  - A further branch while in DRAIN overwrites `redirect_pc` and stays in DRAIN.
  - `instr_valid` stays 0 throughout DRAIN.
- Reset mid-operation: returns to the reset values next edge, abandoning any in-flight request. Instruction memory is reset by the same `reset`.

## Timing
- Outputs are registered: `instr` is visible the cycle after the `imem_ready` that returned it.
- Zero-wait memory (`imem_ready` in the same cycle as request): one instruction per cycle. First `instr_valid` is 2 cycles after `reset` deasserts.
- Branch penalty with zero-wait memory:
  - Branch in cycle t → request to `branchPC` in t+1 → `instr_valid` in t+2.
  - Each DRAIN cycle adds one cycle.
- `stall` is sampled combinationally each cycle and may change every cycle.
- `imem_req`/`imem_addr` are functions of state only, with no combinational path from `stall`, `isBranchTaken` or `imem_ready`.
- Maximum instructions held: 2 (output + skid). No instruction is lost or duplicated across any stall pattern.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning `addr`: `pc`/`instr` = 0/0, 4/4, 8/8 on consecutive cycles; all outputs at reset values during `reset`.
- Zero-wait memory, `stall` high 3 cycles while `pc`=8: `pc` holds 8, skid holds 12, `imem_req`=0 in HOLD. Release → 12 then 16, with no gap and no duplicate.
- Memory with 2-cycle latency: `instr_valid` alternates with bubbles, carrying `instr`=NOP, and `imem_addr` stays stable until `imem_ready`.
- Branch to 32'h0000_0100 while a 3-cycle request to 0x20 is in flight: DRAIN until ready, 0x20 data never appears, next valid `pc`=0x100.
- Branch while in HOLD with `stall`=1: skid discarded, `instr_valid`=0, next valid `pc`=`branchPC`. `branchPC`=0x103 fetches 0x100.
- `fetch_pc`=32'hFFFF_FFFC: next fetch address 0. `reset` asserted during DRAIN → next request at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// SimpleRISC instruction fetch stage: PC sequencing, instruction memory handshake,
// one-entry skid register for downstream stalls and branch redirect with drain.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state_q,       state_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] skid_pc_q,     skid_pc_d;
    logic [31:0] skid_instr_q,  skid_instr_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic        valid_q,       valid_d;
    logic        req_q,         req_d;

    logic        out_free_s;
    logic [31:0] branch_tgt_s;

    // Next-state logic for the fetch FSM, output register and skid register
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        out_free_s    = !valid_q || !stall;
        branch_tgt_s  = branchPC & 32'hFFFF_FFFC;

        case (state_q)
            S_FETCH: begin
                if (isBranchTaken) begin
                    valid_d = 1'b0;
                    instr_d = NOP;
                    // Only a request actually outstanding needs draining
                    if (req_q && !imem_ready) begin
                        redirect_pc_d = branch_tgt_s;
                        state_d       = S_DRAIN;
                    end else begin
                        fetch_pc_d = branch_tgt_s;
                        state_d    = S_FETCH;
                    end
                end else if (imem_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (out_free_s) begin
                        pc_d    = fetch_pc_q;
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                    end else begin
                        skid_pc_d    = fetch_pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP;
                end else begin
                    valid_d = valid_q;
                end
            end
            S_HOLD: begin
                if (isBranchTaken) begin
                    valid_d    = 1'b0;
                    instr_d    = NOP;
                    fetch_pc_d = branch_tgt_s;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    pc_d    = skid_pc_q;
                    instr_d = skid_instr_q;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                instr_d = NOP;
                if (isBranchTaken) begin
                    redirect_pc_d = branch_tgt_s;
                    state_d       = S_DRAIN;
                end else if (imem_ready) begin
                    fetch_pc_d = redirect_pc_q;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                valid_d = 1'b0;
                instr_d = NOP;
                state_d = S_FETCH;
            end
        endcase

        // Request is registered from the next state so it never depends on inputs combinationally
        req_d = (state_d != S_HOLD);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            skid_pc_q     <= 32'h0000_0000;
            skid_instr_q  <= NOP;
            pc_q          <= 32'h0000_0000;
            instr_q       <= NOP;
            valid_q       <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            req_q         <= req_d;
        end
    end

    // fetch_pc is only updated when a response completes, so it doubles as the held address
    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule
